// File: rtl/if_stage.sv
// Instruction fetch stage: drives the fetch PC to imem and buffers returned
// instructions in a small in-order queue presented to decode.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc,
  input  logic [31:0] ir,
  input  logic        stall_imem,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [63:0] id_pc,
  output logic        id_rvc
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FQ_DEPTH);

  logic [63:0]      pc_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic [63:0] ent_pc  [FQ_DEPTH];
  logic [31:0] ent_ir  [FQ_DEPTH];
  logic        ent_rvc [FQ_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic rvc;

  assign rvc  = (ir[1:0] != 2'b11);
  assign full = (count_reg == FULL_COUNT);
  // Redirect squashes both ends of the queue in the same cycle.
  assign pop  = (count_reg != '0) && id_ready && !redirect;
  assign push = !stall_imem && !redirect && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (redirect) begin
      pc_reg    <= {redirect_pc[63:1], 1'b0};
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        pc_reg   <= pc_reg + (rvc ? 64'd2 : 64'd4);
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Entries are cleared on reset so id_* read as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        ent_pc[i]  <= '0;
        ent_ir[i]  <= '0;
        ent_rvc[i] <= 1'b0;
      end
    end else if (push) begin
      ent_pc[tail_reg]  <= pc_reg;
      ent_ir[tail_reg]  <= ir;
      ent_rvc[tail_reg] <= rvc;
    end
  end

  assign pc       = pc_reg;
  assign id_valid = (count_reg != '0);
  assign id_pc    = ent_pc[head_reg];
  assign id_ir    = ent_ir[head_reg];
  assign id_rvc   = ent_rvc[head_reg];

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: a table of per-cycle stimulus with
// hand-computed post-edge outputs, followed by a hand-written drain sequence.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [63:0] pc;
  logic [31:0] ir;
  logic        stall_imem;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [63:0] id_pc;
  logic        id_rvc;

  if_stage #(
    .RESET_PC(64'h8000_0000),
    .FQ_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .ir(ir),
    .stall_imem(stall_imem),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_ir(id_ir),
    .id_pc(id_pc),
    .id_rvc(id_rvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [63:0] rpc;
    logic [31:0] ir;
    logic        ready;
    logic [63:0] e_pc;
    logic        e_valid;
    logic        chk_id;
    logic [63:0] e_id_pc;
    logic [31:0] e_id_ir;
    logic        e_rvc;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  localparam logic [63:0] B = 64'h8000_0000;

  function automatic vec_t mk(input logic r, input logic st, input logic rd,
                              input logic [63:0] rpc, input logic [31:0] i,
                              input logic rdy, input logic [63:0] epc,
                              input logic ev, input logic ck,
                              input logic [63:0] eidpc, input logic [31:0] eidir,
                              input logic ervc);
    vec_t v;
    v.rst = r; v.stall = st; v.redirect = rd; v.rpc = rpc; v.ir = i;
    v.ready = rdy; v.e_pc = epc; v.e_valid = ev; v.chk_id = ck;
    v.e_id_pc = eidpc; v.e_id_ir = eidir; v.e_rvc = ervc;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [63:0] e_pc,
                               input logic e_valid, input logic chk_id,
                               input logic [63:0] e_id_pc, input logic [31:0] e_id_ir,
                               input logic e_rvc);
    if (pc !== e_pc) begin
      n_err++;
      $display("FAIL %s pc: got %h expected %h", tag, pc, e_pc);
    end
    if (id_valid !== e_valid) begin
      n_err++;
      $display("FAIL %s id_valid: got %b expected %b", tag, id_valid, e_valid);
    end
    if (chk_id) begin
      if (id_pc !== e_id_pc) begin
        n_err++;
        $display("FAIL %s id_pc: got %h expected %h", tag, id_pc, e_id_pc);
      end
      if (id_rvc !== e_rvc) begin
        n_err++;
        $display("FAIL %s id_rvc: got %b expected %b", tag, id_rvc, e_rvc);
      end
      // Upper half of a compressed instruction is don't-care.
      if ((e_rvc && id_ir[15:0] !== e_id_ir[15:0]) || (!e_rvc && id_ir !== e_id_ir)) begin
        n_err++;
        $display("FAIL %s id_ir: got %h expected %h", tag, id_ir, e_id_ir);
      end
    end
  endtask

  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [63:0] rpc, input logic [31:0] i, input logic rdy);
    rst = r; stall_imem = st; redirect = rd; redirect_pc = rpc; ir = i; id_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; stall_imem = 1'b1; redirect = 1'b0; redirect_pc = '0;
    ir = '0; id_ready = 1'b0;

    //          rst st rd rpc                      ir            rdy pc                       v  ck id_pc                    id_ir         rvc
    vecs.push_back(mk(1, 0, 0, 64'h0,                32'h0000_0013, 1, B,                       0, 1, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 64'h0,                32'h0000_0013, 1, B,                       0, 1, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0013, 1, B + 4,                   1, 1, B,                       32'h0000_0013, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0093, 1, B + 8,                   1, 1, B + 4,                   32'h0000_0093, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0113, 0, B + 12,                  1, 1, B + 4,                   32'h0000_0093, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0193, 0, B + 12,                  1, 1, B + 4,                   32'h0000_0093, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0193, 0, B + 12,                  1, 1, B + 4,                   32'h0000_0093, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0193, 0, B + 12,                  1, 1, B + 4,                   32'h0000_0093, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0193, 0, B + 12,                  1, 1, B + 4,                   32'h0000_0093, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0193, 1, B + 16,                  1, 1, B + 8,                   32'h0000_0113, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,                32'h0000_0213, 1, B + 16,                  1, 1, B + 12,                  32'h0000_0193, 0));
    vecs.push_back(mk(0, 1, 0, 64'h0,                32'h0000_0213, 1, B + 16,                  0, 0, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 64'h0,                32'h0000_0213, 1, B + 16,                  0, 0, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 64'h0,                32'h0000_0213, 1, B + 16,                  0, 0, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'hABCD_0001, 0, B + 18,                  1, 1, B + 16,                  32'hABCD_0001, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0002, 0, B + 20,                  1, 1, B + 16,                  32'hABCD_0001, 1));
    vecs.push_back(mk(0, 1, 1, 64'h8000_1235,        32'h0000_0013, 1, 64'h8000_1234,           0, 0, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0013, 0, 64'h8000_1238,           1, 1, 64'h8000_1234,           32'h0000_0013, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0093, 0, 64'h8000_123C,           1, 1, 64'h8000_1234,           32'h0000_0013, 0));
    vecs.push_back(mk(1, 0, 1, 64'h8000_5000,        32'h0000_0013, 1, B,                       0, 1, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 64'h0,                32'h0000_0013, 1, B,                       0, 1, 64'h0,                   32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0013, 1, B + 4,                   1, 1, B,                       32'h0000_0013, 0));
    vecs.push_back(mk(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'h0,                32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0013, 1, 64'h0000_0000_0000_0002, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_0013, 0));
    vecs.push_back(mk(0, 0, 0, 64'h0,                32'h0000_0001, 1, 64'h0000_0000_0000_0004, 1, 1, 64'h0000_0000_0000_0002, 32'h0000_0001, 1));

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].stall, vecs[k].redirect, vecs[k].rpc, vecs[k].ir, vecs[k].ready);
      n_vec++;
      check_outputs($sformatf("vec%0d", k), vecs[k].e_pc, vecs[k].e_valid, vecs[k].chk_id,
                    vecs[k].e_id_pc, vecs[k].e_id_ir, vecs[k].e_rvc);
      $display("vec%0d pc=%h id_valid=%b id_pc=%h id_ir=%h id_rvc=%b",
               k, pc, id_valid, id_pc, id_ir, id_rvc);
    end

    // Fill under backpressure, hold, then drain and confirm in-order delivery.
    step(1, 0, 0, 64'h0, 32'h0000_0013, 0);
    n_vec++;
    check_outputs("seq_reset", B, 1'b0, 1'b1, 64'h0, 32'h0, 1'b0);
    step(0, 0, 0, 64'h0, 32'h1111_1113, 0);
    step(0, 0, 0, 64'h0, 32'h2222_2223, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 64'h0, 32'h3333_3333, 0);
      n_vec++;
      check_outputs($sformatf("seq_hold%0d", c), B + 8, 1'b1, 1'b1, B, 32'h1111_1113, 1'b0);
      $display("seq_hold%0d pc=%h id_pc=%h id_ir=%h", c, pc, id_pc, id_ir);
    end
    step(0, 1, 0, 64'h0, 32'h3333_3333, 1);
    n_vec++;
    check_outputs("seq_drain0", B + 8, 1'b1, 1'b1, B + 4, 32'h2222_2223, 1'b0);
    $display("seq_drain0 pc=%h id_pc=%h id_ir=%h", pc, id_pc, id_ir);
    step(0, 1, 0, 64'h0, 32'h3333_3333, 1);
    n_vec++;
    check_outputs("seq_drain1", B + 8, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0);
    $display("seq_drain1 pc=%h id_valid=%b", pc, id_valid);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, PC loaded on reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 2, fetch-queue entries (power of two, >=2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port pc  output  64  fetch address driven to imem.
REQ-007 SHALL have port ir  input  32  instruction from imem for current pc, valid when stall_imem=0.
REQ-008 SHALL have port stall_imem  input  1  imem miss/refill in progress; ir invalid.
REQ-009 SHALL have port redirect  input  1  branch/jump/trap redirect request from execute.
REQ-010 SHALL have port redirect_pc  input  64  redirect target.
REQ-011 SHALL have port id_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port id_ready  input  1  decode accepts the head this cycle.
REQ-013 SHALL have port id_ir  output  32  head instruction; upper 16 bits are don't-care when id_rvc=1.
REQ-014 SHALL have port id_pc  output  64  head instruction address.
REQ-015 SHALL have port id_rvc  output  1  head is a 16-bit compressed instruction.

Function
REQ-016 SHALL classify an instruction as compressed when ir[1:0] != 2'b11.
REQ-017 SHALL perform a push when stall_imem=0, redirect=0, and (queue not full OR a pop occurs in the same cycle).
REQ-018 SHALL, on a push, write {pc, ir, rvc} at the tail and advance pc by 2 if rvc=1, else by 4, modulo 2^64.
REQ-019 SHALL hold pc unchanged in any cycle without a push or redirect.
REQ-020 SHALL perform a pop when id_valid=1 and id_ready=1, advancing the head by one entry.
REQ-021 SHALL, on redirect=1, flush all queue entries and set pc to {redirect_pc[63:1],1'b0} on the next edge, with no push or pop taking effect that cycle.
REQ-022 SHALL give redirect priority over stall_imem, push, and pop.
REQ-023 SHALL deassert id_valid in the cycle after a redirect; the first post-redirect instruction SHALL reach id_valid no earlier than 1 cycle after pc shows the new target.
REQ-024 SHALL add one cycle of latency from push to visibility: an entry pushed at edge N SHALL be presented on id_* after edge N.
REQ-025 SHALL drive id_ir, id_pc, and id_rvc directly from the head-entry registers, with no combinational path from ir.
REQ-026 SHALL keep id_* stable while id_valid=1 and id_ready=0.
REQ-027 SHALL track occupancy with a count of width clog2(FQ_DEPTH)+1 and head/tail pointers that wrap modulo FQ_DEPTH.
REQ-028 SHALL, when full with no pop, perform no push and SHALL not overwrite any entry.
REQ-029 SHALL leave count unchanged on a simultaneous push and pop, including the full case.
REQ-030 SHALL, when empty, hold id_valid=0 and ignore id_ready.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, set pc=RESET_PC, count=0, head=tail=0, and id_valid=0.
REQ-032 SHALL give rst priority over redirect, push, and pop, and discard any in-flight entry.
REQ-033 SHALL drive id_ir, id_pc, and id_rvc to 0 after reset until the first push.

Verification
REQ-034 SHALL cover reset release, stall_imem=0, ir=32'h0000_0013, id_ready=1: pc sequence 8000_0000, 8000_0004, 8000_0008; id_pc=8000_0000 one cycle after the first push.
REQ-035 SHALL cover compressed instruction: ir=32'hxxxx_0001 at pc 8000_0000: next pc=8000_0002; id_rvc=1.
REQ-036 SHALL cover backpressure: id_ready=0 for 5 cycles: count saturates at 2, pc freezes at 8000_0008, id_* stable, then drains in order once id_ready=1.
REQ-037 SHALL cover redirect while full with stall_imem=1 and redirect_pc=64'h8000_1235: next cycle pc=8000_1234, id_valid=0, queue empty.
REQ-038 SHALL cover stall: stall_imem=1 for 4 cycles mid-stream: no push, pc unchanged, queued entries still pop.
REQ-039 SHALL cover reset mid-operation: rst=1 with 2 entries queued and redirect=1: next cycle pc=8000_0000, id_valid=0.
